// File: rtl/mono_conf_pkg.sv
// Shared types and default constants for the MONOPIX configuration sequencer.
package mono_conf_pkg;

  localparam int unsigned MEM_AW_DEF    = 10;
  localparam int unsigned CNT_W_DEF     = 16;
  localparam int unsigned HALF_PER_DEF  = 4;
  localparam int unsigned LD_CYCLES_DEF = 4;

  localparam logic MODE_GLOBAL = 1'b0;
  localparam logic MODE_PIXEL  = 1'b1;

  typedef enum logic [2:0] {IDLE, CLR, FETCH, SHIFT, LOAD, FIN} state_t;

  // Sub-phases of LOAD: settle low, load pulse, trailing quiet time.
  typedef enum logic [1:0] {LD_PRE, LD_PULSE, LD_POST} ld_ph_t;

endpackage

// File: rtl/mono_conf_tick.sv
// HALF_PER divider: strobes on the last cycle of each half period, phase-tagged.
module mono_conf_tick
  import mono_conf_pkg::*;
#(
  parameter int unsigned HALF_PER = HALF_PER_DEF
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned TW = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;

  logic [TW-1:0] cnt;
  logic          phase;
  logic          tick_c;

  assign tick_c = (cnt == TW'(HALF_PER - 1)) && !clr;
  assign rise_c = tick_c && !phase;
  assign fall_c = tick_c && phase;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (tick_c) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/mono_conf_seq.sv
// MONOPIX configuration chain sequencer: streams a byte buffer into SR_In/Clk_Conf, then LdDAC/LdPix.
// Optional SR_out capture into RB_* ports when MONO_CONF_READBACK_EN is defined.
module mono_conf_seq
  import mono_conf_pkg::*;
#(
  parameter int unsigned MEM_AW    = MEM_AW_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned HALF_PER  = HALF_PER_DEF,
  parameter int unsigned LD_CYCLES = LD_CYCLES_DEF
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              START,
  input  logic              MODE,
  input  logic              RST_FIRST,
  input  logic [CNT_W-1:0]  BIT_CNT,
  input  logic              HIT_EN,
  output logic              BUSY,
  output logic              DONE,
  output logic [MEM_AW-1:0] MEM_ADDR,
  output logic              MEM_RD,
  input  logic [7:0]        MEM_DATA,
  output logic              Clk_Conf,
  output logic              SR_In,
  input  logic              SR_out,
  output logic              LdDAC,
  output logic              LdPix,
  output logic              SR_RST,
  output logic              SR_EN
`ifdef MONO_CONF_READBACK_EN
  ,
  output logic              RB_WE,
  output logic [MEM_AW-1:0] RB_ADDR,
  output logic [7:0]        RB_DATA
`endif
);

  localparam int unsigned LCW = (LD_CYCLES > 1) ? $clog2(LD_CYCLES) : 1;

  state_t           state;
  ld_ph_t           ld_ph;
  logic             mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] bit_idx;
  logic [7:0]       byte_q;
  logic [7:0]       nxt_q;
  logic             cap_q;
  logic [LCW-1:0]   ld_cnt;

  logic             tick_clr_c;
  logic             rise_c;
  logic             fall_c;
  logic             last_bit_c;
  logic [CNT_W-1:0] nidx_c;
  logic [2:0]       npos_c;
  logic             pf_c;

  // Divider runs only in timed phases; idling it keeps every timed phase starting from zero.
  assign tick_clr_c = !((state == CLR) || (state == SHIFT) ||
                        ((state == LOAD) && (ld_ph != LD_PULSE)));

  mono_conf_tick #(.HALF_PER(HALF_PER)) u_tick (
    .CLK    (CLK),
    .nRST   (nRST),
    .clr    (tick_clr_c),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  assign last_bit_c = (bit_idx == (cnt_q - CNT_W'(1)));
  assign nidx_c     = bit_idx + CNT_W'(1);
  assign npos_c     = nidx_c[2:0];
  // Prefetch the following byte as its predecessor's bit 7 starts.
  assign pf_c       = (npos_c == 3'd7) && ((nidx_c + CNT_W'(1)) < cnt_q);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      ld_ph    <= LD_PRE;
      mode_q   <= MODE_GLOBAL;
      cnt_q    <= '0;
      bit_idx  <= '0;
      byte_q   <= '0;
      nxt_q    <= '0;
      cap_q    <= 1'b0;
      ld_cnt   <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      MEM_ADDR <= '0;
      MEM_RD   <= 1'b0;
      Clk_Conf <= 1'b0;
      SR_In    <= 1'b0;
      LdDAC    <= 1'b0;
      LdPix    <= 1'b0;
      SR_RST   <= 1'b0;
      SR_EN    <= 1'b0;
    end else begin
      MEM_RD <= 1'b0;
      DONE   <= 1'b0;
      SR_EN  <= 1'b0;
      cap_q  <= MEM_RD;
      case (state)
        IDLE: begin
          if (START) begin
            mode_q <= MODE;
            cnt_q  <= BIT_CNT;
            BUSY   <= 1'b1;
            if (RST_FIRST) begin
              state  <= CLR;
              SR_RST <= 1'b1;
            end else begin
              state    <= FETCH;
              MEM_RD   <= (BIT_CNT != '0);
              MEM_ADDR <= '0;
            end
          end else begin
            SR_EN <= HIT_EN;
          end
        end
        CLR: begin
          if (fall_c) begin
            SR_RST <= 1'b0;
          end else if (rise_c && !SR_RST) begin
            state    <= FETCH;
            MEM_RD   <= (cnt_q != '0);
            MEM_ADDR <= '0;
          end
        end
        FETCH: begin
          if (cnt_q == '0) begin
            state <= FIN;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
          end else if (cap_q) begin
            byte_q  <= MEM_DATA;
            SR_In   <= MEM_DATA[7];
            bit_idx <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (cap_q) begin
            nxt_q <= MEM_DATA;
          end
          if (rise_c) begin
            Clk_Conf <= 1'b1;
          end else if (fall_c) begin
            Clk_Conf <= 1'b0;
            if (last_bit_c) begin
              state <= LOAD;
              ld_ph <= LD_PRE;
            end else begin
              bit_idx <= nidx_c;
              if (npos_c == 3'd0) begin
                byte_q <= nxt_q;
                SR_In  <= nxt_q[7];
              end else begin
                SR_In <= byte_q[3'd7 - npos_c];
              end
              if (pf_c) begin
                MEM_RD   <= 1'b1;
                MEM_ADDR <= MEM_AW'((nidx_c + CNT_W'(1)) >> 3);
              end
            end
          end
        end
        LOAD: begin
          case (ld_ph)
            LD_PRE: begin
              if (rise_c) begin
                if (mode_q == MODE_PIXEL) LdPix <= 1'b1;
                else                      LdDAC <= 1'b1;
                ld_cnt <= '0;
                ld_ph  <= LD_PULSE;
              end
            end
            LD_PULSE: begin
              if (ld_cnt == LCW'(LD_CYCLES - 1)) begin
                LdDAC <= 1'b0;
                LdPix <= 1'b0;
                ld_ph <= LD_POST;
              end else begin
                ld_cnt <= ld_cnt + LCW'(1);
              end
            end
            default: begin
              if (rise_c) begin
                state <= FIN;
                DONE  <= 1'b1;
                BUSY  <= 1'b0;
              end
            end
          endcase
        end
        FIN: begin
          state <= IDLE;
          SR_EN <= HIT_EN;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MONO_CONF_READBACK_EN
  logic [7:0] rb_acc;
  logic [7:0] rb_nxt_c;
  logic [2:0] pos_c;

  assign pos_c = bit_idx[2:0];

  // Byte being assembled with the current SR_out sample merged in, MSB first.
  always_comb begin
    rb_nxt_c = (pos_c == 3'd0) ? 8'h00 : rb_acc;
    rb_nxt_c[3'd7 - pos_c] = SR_out;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rb_acc  <= '0;
      RB_WE   <= 1'b0;
      RB_ADDR <= '0;
      RB_DATA <= '0;
    end else begin
      RB_WE <= 1'b0;
      if ((state == SHIFT) && rise_c) begin
        rb_acc <= rb_nxt_c;
        if ((pos_c == 3'd7) || last_bit_c) begin
          RB_WE   <= 1'b1;
          RB_ADDR <= MEM_AW'(bit_idx >> 3);
          RB_DATA <= rb_nxt_c;
        end
      end
    end
  end
`else
  logic unused_sr_out;
  assign unused_sr_out = SR_out;
`endif

endmodule

// File: tb/tb_mono_conf_seq.sv
// Scoreboard bench for mono_conf_seq: stimulus queues expectations, a negedge monitor checks them.
module tb_mono_conf_seq;
  import mono_conf_pkg::*;

  localparam int H  = 4;
  localparam int LD = 4;
  localparam int AW = 10;
  localparam int CW = 16;

  logic          CLK = 1'b0;
  logic          nRST = 1'b1;
  logic          START = 1'b0;
  logic          MODE = 1'b0;
  logic          RST_FIRST = 1'b0;
  logic [CW-1:0] BIT_CNT = '0;
  logic          HIT_EN = 1'b0;
  logic          BUSY, DONE, MEM_RD, Clk_Conf, SR_In, SR_out, LdDAC, LdPix, SR_RST, SR_EN;
  logic [AW-1:0] MEM_ADDR;
  logic [7:0]    MEM_DATA = 8'h00;
`ifdef MONO_CONF_READBACK_EN
  logic          RB_WE;
  logic [AW-1:0] RB_ADDR;
  logic [7:0]    RB_DATA;
`endif

  mono_conf_seq #(.MEM_AW(AW), .CNT_W(CW), .HALF_PER(H), .LD_CYCLES(LD)) dut (
    .CLK(CLK), .nRST(nRST), .START(START), .MODE(MODE), .RST_FIRST(RST_FIRST),
    .BIT_CNT(BIT_CNT), .HIT_EN(HIT_EN), .BUSY(BUSY), .DONE(DONE),
    .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD), .MEM_DATA(MEM_DATA),
    .Clk_Conf(Clk_Conf), .SR_In(SR_In), .SR_out(SR_out),
    .LdDAC(LdDAC), .LdPix(LdPix), .SR_RST(SR_RST), .SR_EN(SR_EN)
`ifdef MONO_CONF_READBACK_EN
    , .RB_WE(RB_WE), .RB_ADDR(RB_ADDR), .RB_DATA(RB_DATA)
`endif
  );

  always #5 CLK = ~CLK;

  // Chip model: config chain output loops straight back to its input.
  assign SR_out = SR_In;

  logic [7:0] mem [0:1023];
  always @(posedge CLK) if (MEM_RD) MEM_DATA <= mem[MEM_ADDR];

  typedef struct { int edges; int dac; int pix; int rst; int lat; } exp_t;
  typedef struct { int addr; int data; } rb_t;
  exp_t exp_q[$];
  bit   exp_bits[$];
  rb_t  rb_q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // START-to-DONE cycles of this implementation: 3 + 2*H*N + 2*H + LD for N > 0
  // (one above the nominal 2 + ... figure), 2 for N = 0; CLR adds 3*H.
  function automatic int lat(input int n, input bit rf);
    int l;
    l = (n == 0) ? 2 : 3 + 2 * H * n + 2 * H + LD;
    if (rf) l += 3 * H;
    return l;
  endfunction

  // Monitor: per-sequence measurements from BUSY rise, checked against the queue at DONE.
  logic cc_prev, busy_prev, srin_prev, done_d;
  int   cyc, edges, dac, pix, rstc, en_bad, srin_bad;
  always @(negedge CLK) begin
    if (!nRST) begin
      cc_prev = 1'b0; busy_prev = 1'b0; srin_prev = 1'b0; done_d = 1'b0;
    end else begin
      if (BUSY && !busy_prev) begin
        cyc = 0; edges = 0; dac = 0; pix = 0; rstc = 0; en_bad = 0; srin_bad = 0;
      end else begin
        cyc++;
      end
      if (Clk_Conf && !cc_prev) begin
        edges++;
        if (exp_bits.size() == 0) chk("edge_expected", 0, 1);
        else chk("sr_in_bit", int'(SR_In), int'(exp_bits.pop_front()));
      end
      if (Clk_Conf && (SR_In != srin_prev)) srin_bad++;
      dac  += int'(LdDAC);
      pix  += int'(LdPix);
      rstc += int'(SR_RST);
      if (BUSY && SR_EN) en_bad++;
      if (done_d) chk("sr_en_after", int'(SR_EN), int'(HIT_EN));
      done_d = DONE;
      if (DONE) begin
        if (exp_q.size() == 0) chk("done_expected", 0, 1);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("edges", edges, e.edges);
          chk("lddac_cycles", dac, e.dac);
          chk("ldpix_cycles", pix, e.pix);
          chk("sr_rst_cycles", rstc, e.rst);
          chk("latency", cyc + 1, e.lat);
          chk("sr_en_busy", en_bad, 0);
          chk("sr_in_stable", srin_bad, 0);
          chk("busy_at_done", int'(BUSY), 0);
        end
      end
`ifdef MONO_CONF_READBACK_EN
      if (RB_WE) begin
        if (rb_q.size() == 0) chk("rb_expected", 0, 1);
        else begin
          rb_t r;
          r = rb_q.pop_front();
          chk("rb_addr", int'(RB_ADDR), r.addr);
          chk("rb_data", int'(RB_DATA), r.data);
        end
      end
`endif
      cc_prev = Clk_Conf; busy_prev = BUSY; srin_prev = SR_In;
    end
  end

  task automatic start_seq(input logic mode, input logic rf, input int n, input logic hit, input bit rec);
    logic [7:0] byt;
    exp_t e;
    HIT_EN = hit;
    for (int i = 0; i < n; i++) begin
      byt = mem[i >> 3];
      exp_bits.push_back(byt[7 - (i % 8)]);
    end
    if (rec) begin
      e.edges = n;
      e.dac   = (n > 0 && mode == MODE_GLOBAL) ? LD : 0;
      e.pix   = (n > 0 && mode == MODE_PIXEL) ? LD : 0;
      e.rst   = rf ? 2 * H : 0;
      e.lat   = lat(n, rf);
      exp_q.push_back(e);
`ifdef MONO_CONF_READBACK_EN
      for (int b = 0; b * 8 < n; b++) begin
        rb_t r;
        int rem;
        rem = n - 8 * b;
        byt = mem[b];
        if (rem < 8) byt = byt & (8'hFF << (8 - rem));
        r.addr = b;
        r.data = int'(byt);
        rb_q.push_back(r);
      end
`endif
    end
    @(posedge CLK); #1;
    MODE = mode; RST_FIRST = rf; BIT_CNT = CW'(n); START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!DONE && k < budget) begin
      @(negedge CLK);
      k++;
    end
    if (!DONE) chk("done_timeout", int'(DONE), 1);
    repeat (4) @(negedge CLK);
  endtask

  initial begin
    int rises, k;
    logic prev;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 29 + 7);

    #1 nRST = 1'b0;
    #1;
    chk("reset_ctl", int'({BUSY, DONE, MEM_RD, Clk_Conf, SR_In, LdDAC, LdPix, SR_RST, SR_EN}), 0);
    chk("reset_addr", int'(MEM_ADDR), 0);
    HIT_EN = 1'b1;
    #20 nRST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("idle_sr_en", int'(SR_EN), 1);
    chk("idle_busy", int'(BUSY), 0);

    // Global register, 16 bits: A5 3C, single LdDAC pulse.
    mem[0] = 8'hA5; mem[1] = 8'h3C;
    start_seq(MODE_GLOBAL, 1'b0, 16, 1'b1, 1'b1);
    wait_done(lat(16, 1'b0) + 20);

    // Full pixel chain with chain reset first.
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 29 + 7) ^ 8'(i >> 2);
    start_seq(MODE_PIXEL, 1'b1, 4645, 1'b1, 1'b1);
    wait_done(lat(4645, 1'b1) + 20);

    // Partial final byte: 11 ones from FF E0.
    mem[0] = 8'hFF; mem[1] = 8'hE0;
    start_seq(MODE_GLOBAL, 1'b0, 11, 1'b0, 1'b1);
    wait_done(lat(11, 1'b0) + 20);

    // Zero-length sequences, with and without chain reset.
    start_seq(MODE_GLOBAL, 1'b0, 0, 1'b1, 1'b1);
    wait_done(lat(0, 1'b0) + 20);
    start_seq(MODE_PIXEL, 1'b1, 0, 1'b0, 1'b1);
    wait_done(lat(0, 1'b1) + 20);

    // START while busy with different settings must not disturb the sequence.
    mem[0] = 8'hA5; mem[1] = 8'h3C;
    start_seq(MODE_GLOBAL, 1'b0, 16, 1'b1, 1'b1);
    repeat (40) @(posedge CLK);
    #1 MODE = MODE_PIXEL; RST_FIRST = 1'b1; BIT_CNT = CW'(3); START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    wait_done(lat(16, 1'b0) + 20);

    // Reset during bit 5: outputs clear at once, no DONE.
    start_seq(MODE_GLOBAL, 1'b0, 16, 1'b1, 1'b0);
    rises = 0; k = 0; prev = 1'b0;
    while (rises < 6 && k < 2000) begin
      @(negedge CLK);
      k++;
      if (Clk_Conf && !prev) rises++;
      prev = Clk_Conf;
    end
    if (rises < 6) chk("abort_wait", rises, 6);
    #2 nRST = 1'b0;
    #1;
    chk("abort_ctl", int'({BUSY, DONE, MEM_RD, Clk_Conf, SR_In, LdDAC, LdPix, SR_RST, SR_EN}), 0);
    chk("abort_addr", int'(MEM_ADDR), 0);
    exp_bits.delete();
    repeat (3) @(negedge CLK);
    #2 nRST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("abort_busy", int'(BUSY), 0);

    // Fresh sequence after the abort.
    start_seq(MODE_PIXEL, 1'b0, 16, 1'b0, 1'b1);
    wait_done(lat(16, 1'b0) + 20);

    chk("pending_records", int'(exp_q.size()), 0);
    chk("pending_bits", int'(exp_bits.size()), 0);
    chk("pending_rb", int'(rb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
